rename_stage: RTL

Register-rename stage of the out-of-order RISC-V pipeline. Sits between Pipeline Buffer #2 (decode output) and dispatch.
- Maps the architectural rs1/rs2/rd of one decoded instruction per cycle to physical tags using a RAT and a free-list FIFO.
- Frees physical registers returned by retire.
- Output is registered; valid/ready handshake on both sides.

---
 rtl/rename_stage.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/rename_stage.sv
// Register-rename stage: maps one decoded instruction per cycle from
// architectural to physical register tags using a RAT and a free-list FIFO.
// Retired old destination tags are returned to the free list.
// Outputs are registered with a valid/ready handshake on both sides.
module rename_stage #(
    parameter int NUM_ARCH = 32,
    parameter int NUM_PHYS = 64,
    parameter int PREG_W   = 6,
    parameter int FL_DEPTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic [31:0]       in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [6:0]        out_opcode,
    output logic [31:0]       out_instr,
    output logic [PREG_W-1:0] out_ps1,
    output logic [PREG_W-1:0] out_ps2,
    output logic [PREG_W-1:0] out_pd,
    output logic [PREG_W-1:0] out_old_pd,
    output logic              out_has_rd,
    input  logic              ret_valid,
    input  logic [PREG_W-1:0] ret_old_pd,
    output logic [5:0]        free_count
);

    localparam int PTR_W = $clog2(FL_DEPTH);
    localparam logic [PTR_W:0] FL_FULL = (PTR_W+1)'(FL_DEPTH);

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;

    logic [PREG_W-1:0] rat       [NUM_ARCH];
    logic [PREG_W-1:0] free_list [FL_DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W:0]    count;

    logic              needs_rd;
    logic              accept;
    logic              alloc;
    logic              push;
    logic [PREG_W-1:0] alloc_tag;

    // Only register-writing opcodes with a non-zero rd consume a tag.
    always_comb begin
        needs_rd = ((in_opcode == OP_RTYPE) || (in_opcode == OP_IMM) ||
                    (in_opcode == OP_LOAD)) && (in_rd != 5'd0);
    end

    // Readiness uses the registered count, so a same-cycle retire cannot
    // rescue an allocation stalled on an empty free list.
    assign in_ready   = (!out_valid || out_ready) && (!needs_rd || (count != '0));
    assign accept     = in_valid && in_ready;
    assign alloc      = accept && needs_rd;
    assign push       = ret_valid && (ret_old_pd != '0) && (count != FL_FULL);
    assign alloc_tag  = free_list[head];
    assign free_count = 6'(count);

    // RAT: identity mapping on reset; rd remapped to the allocated tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ARCH; i++) begin
                rat[i] <= PREG_W'(i);
            end
        end else if (alloc) begin
            rat[in_rd] <= alloc_tag;
        end
    end

    // Free-list storage: starts holding the tags above the architectural range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                free_list[i] <= PREG_W'(NUM_ARCH + i);
            end
        end else if (push) begin
            free_list[tail] <= ret_old_pd;
        end
    end

    // Free-list pointers and occupancy; full and empty both have head==tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= FL_FULL;
        end else begin
            if (alloc) begin
                head <= head + 1'b1;
            end
            if (push) begin
                tail <= tail + 1'b1;
            end
            case ({alloc, push})
                2'b10:   count <= count - 1'b1;
                2'b01:   count <= count + 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Output register: loads on accept (sources read pre-update RAT), holds on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_opcode <= '0;
            out_instr  <= '0;
            out_ps1    <= '0;
            out_ps2    <= '0;
            out_pd     <= '0;
            out_old_pd <= '0;
            out_has_rd <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_opcode <= in_opcode;
            out_instr  <= in_instr;
            out_ps1    <= rat[in_rs1];
            out_ps2    <= rat[in_rs2];
            out_pd     <= needs_rd ? alloc_tag : '0;
            out_old_pd <= needs_rd ? rat[in_rd] : '0;
            out_has_rd <= needs_rd;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    // Flag a retire that would overflow the free list; the push itself is dropped.
    always_ff @(posedge clk) begin
        if (rst_n && ret_valid && (ret_old_pd != '0)) begin
            assert (count != FL_FULL)
                else $error("rename_stage: retire push into full free list (tag %0d)", ret_old_pd);
        end
    end

endmodule
